// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: serialises byte/half/word loads and stores onto a byte-wide RAM
// with 1-cycle read latency, flagging misaligned or illegal sizes.
module ram_access_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [31:0]       i_wdata,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic [ADDR_W-1:0] o_ram_raddr,
    output logic [7:0]        o_ram_wdata,
    input  logic [7:0]        i_ram_rdata
);
    typedef enum logic [1:0] {IDLE, XFER, RLAST, FIN} state_t;
    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d, size_q;
    logic              wr_q, uns_q, err_q, we_q;
    logic [23:0]       wdata_q, buf_q;
    logic [31:0]       rdata_q, shifted, ext;
    logic [ADDR_W-1:0] waddr_q, raddr_q;
    logic [7:0]        ram_wdata_q;
    logic              accept, bad, last, capture;
    always_comb begin
        accept  = (state_q == IDLE) && i_req;
        bad     = (i_size == 2'b11) || (i_size == 2'b01 && i_addr[0]) || (i_size == 2'b10 && i_addr[1:0] != 2'b00);
        last    = k_q == (size_q == 2'b10 ? 2'd3 : size_q == 2'b01 ? 2'd1 : 2'd0);
        // read data trails the address by one cycle, so XFER k captures byte k-1
        capture = !wr_q && ((state_q == XFER && k_q != 2'd0) || state_q == RLAST);
        shifted = {i_ram_rdata, buf_q};
        ext     = size_q == 2'b10 ? shifted :
                  size_q == 2'b01 ? {{16{!uns_q & shifted[31]}}, shifted[31:16]} :
                                    {{24{!uns_q & shifted[31]}}, shifted[31:24]};
    end
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE:  if (i_req) begin
                       state_d = bad ? FIN : XFER;
                       k_d     = 2'd0;
                   end
            XFER:  if (last) state_d = wr_q ? FIN : RLAST;
                   else k_d = k_q + 2'd1;
            RLAST: state_d = FIN;
            FIN:   begin
                       state_d = IDLE;
                       k_d     = 2'd0;
                   end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            size_q      <= 2'd0;
            wr_q        <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            buf_q       <= '0;
            rdata_q     <= '0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                wr_q    <= i_wr;
                size_q  <= i_size;
                uns_q   <= i_unsigned;
                wdata_q <= i_wdata[31:8];
                err_q   <= bad;
                if (!bad && i_wr) begin
                    we_q        <= 1'b1;
                    waddr_q     <= i_addr;
                    ram_wdata_q <= i_wdata[7:0];
                end else if (!bad) raddr_q <= i_addr;
            end
            // RAM port registers are preloaded with the next XFER cycle's values
            if (state_q == XFER) begin
                if (last) we_q <= 1'b0;
                else if (wr_q) begin
                    waddr_q     <= waddr_q + ADDR_W'(1);
                    ram_wdata_q <= wdata_q[{k_q, 3'b000} +: 8];
                end else raddr_q <= raddr_q + ADDR_W'(1);
            end
            if (capture) buf_q <= shifted[31:8];
            if (state_q == RLAST) rdata_q <= ext;
        end
    end
    assign o_ready     = state_q == IDLE;
    assign o_done      = state_q == FIN;
    assign o_err       = (state_q == FIN) && err_q;
    assign o_rdata     = rdata_q;
    assign o_ram_we    = we_q;
    assign o_ram_waddr = waddr_q;
    assign o_ram_raddr = raddr_q;
    assign o_ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed and random accesses against an array-based RAM reference model.
module tb_ram_access_ctrl;
    localparam int AW = 11;
    logic          clk = 1'b0, rst_n = 1'b0, ram_init = 1'b1;
    logic          i_req = 1'b0, i_wr = 1'b0, i_unsigned = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [1:0]    i_size = '0;
    logic [31:0]   i_wdata = '0;
    logic          o_ready, o_done, o_err, o_ram_we;
    logic [31:0]   o_rdata;
    logic [AW-1:0] o_ram_waddr, o_ram_raddr;
    logic [7:0]    o_ram_wdata, i_ram_rdata;
    logic [7:0]    mem [2048];
    logic [7:0]    ref_mem [2048];
    logic [31:0]   exp_rdata = '0;
    int            n_checks = 0, n_err = 0;

    ram_access_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr),
        .i_size(i_size), .i_unsigned(i_unsigned), .i_wdata(i_wdata),
        .o_ready(o_ready), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
        .o_ram_we(o_ram_we), .o_ram_waddr(o_ram_waddr), .o_ram_raddr(o_ram_raddr),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_init) for (int i = 0; i < 2048; i++) mem[i] <= 8'(i * 7 + 3);
        else if (o_ram_we) mem[o_ram_waddr] <= o_ram_wdata;
        i_ram_rdata <= mem[o_ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one access starting at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic access(input logic wr, input logic [AW-1:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd);
        int n, lat, cyc, a;
        logic bad;
        logic [31:0] val;
        logic [31:0] exp_w[$], got_w[$];
        a   = int'(addr);
        n   = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
        bad = size == 2'd3 || (a % n) != 0;
        lat = bad ? 1 : wr ? n + 1 : n + 2;
        if (!bad && wr)
            for (int k = 0; k < n; k++) begin
                ref_mem[a + k] = wd[8*k +: 8];
                exp_w.push_back({9'd0, 4'(k + 1), AW'(a + k), wd[8*k +: 8]});
            end
        if (!bad && !wr) begin
            val = 0;
            for (int k = 0; k < n; k++) val = val + (32'(ref_mem[a + k]) << (8 * k));
            if (!uns && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 1);
            exp_rdata = val;
        end
        i_req = 1'b1; i_wr = wr; i_addr = addr; i_size = size; i_unsigned = uns; i_wdata = wd;
        chk("ready_idle", 32'(o_ready), 1);
        @(posedge clk);
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (o_ram_we) got_w.push_back({9'd0, 4'(cyc), o_ram_waddr, o_ram_wdata});
            if (o_done) break;
            chk("busy_ready", 32'(o_ready), 0);
            chk("err_low", 32'(o_err), 0);
            i_req = 1'($urandom); i_addr = AW'($urandom); i_wdata = $urandom;
            i_wr = 1'($urandom); i_size = 2'($urandom); i_unsigned = 1'($urandom);
        end
        chk("latency", cyc, lat);
        chk("err", 32'(o_err), 32'(bad));
        chk("rdata", o_rdata, exp_rdata);
        chk("fin_ready", 32'(o_ready), 0);
        i_req = 1'b0;
        chk("nwrites", got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) chk("write", got_w[i], exp_w[i]);
        @(negedge clk);
        chk("done_pulse", 32'(o_done), 0);
        chk("ready_after", 32'(o_ready), 1);
    endtask

    initial begin
        logic [1:0]    sz;
        logic [AW-1:0] ad;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i * 7 + 3);
        repeat (3) @(negedge clk);
        ram_init = 1'b0;
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_we", 32'(o_ram_we), 0);
        chk("rst_waddr", 32'(o_ram_waddr), 0);
        chk("rst_raddr", 32'(o_ram_raddr), 0);
        chk("rst_wdata", 32'(o_ram_wdata), 0);
        rst_n = 1'b1;
        @(negedge clk);
        access(1, 11'h010, 2'd2, 0, 32'hDEADBEEF);
        access(0, 11'h013, 2'd0, 0, 0);
        chk("ld_byte_s", o_rdata, 32'hFFFFFFDE);
        access(0, 11'h013, 2'd0, 1, 0);
        chk("ld_byte_u", o_rdata, 32'h000000DE);
        access(0, 11'h012, 2'd1, 0, 0);
        chk("ld_half_s", o_rdata, 32'hFFFFDEAD);
        access(0, 11'h010, 2'd2, 0, 0);
        chk("ld_word", o_rdata, 32'hDEADBEEF);
        access(0, 11'h011, 2'd2, 0, 0);
        access(0, 11'h000, 2'd3, 0, 0);
        chk("err_hold", o_rdata, 32'hDEADBEEF);
        access(1, 11'h7FC, 2'd2, 0, 32'h11223344);
        access(0, 11'h7FC, 2'd2, 0, 0);
        chk("ld_top", o_rdata, 32'h11223344);
        // abort a word store to 0x020 during its second transfer cycle
        i_req = 1'b1; i_wr = 1'b1; i_addr = 11'h020; i_size = 2'd2; i_wdata = 32'hA5C35A3C;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        i_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(o_ram_we), 0);
        chk("abort_done", 32'(o_done), 0);
        chk("abort_rdata", o_rdata, 0);
        chk("abort_ready", 32'(o_ready), 1);
        ref_mem[32'h020] = 8'h3C;
        exp_rdata = 0;
        repeat (2) @(negedge clk);
        chk("abort_nodone", 32'(o_done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        access(0, 11'h020, 2'd2, 0, 0);
        access(0, 11'h024, 2'd2, 0, 0);
        repeat (300) begin
            sz = 2'($urandom);
            ad = AW'($urandom);
            if ($urandom_range(0, 3) != 0) ad[1:0] = sz == 2'd2 ? 2'b00 : sz == 2'd1 ? {ad[1], 1'b0} : ad[1:0];
            access(1'($urandom), ad, sz, 1'($urandom), $urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
